// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants, top-octave note table and FSM state type
package dds_pkg;

    localparam int SEMITONES = 12;
    localparam int MAX_OCT   = 10;
    localparam int ACC_BITS  = 28;

    localparam logic [31:0] ACC_MASK = 32'((33'd1 << ACC_BITS) - 33'd1);

    // Tuning words for notes 120..131; every lower octave is a right shift of these.
    localparam logic [15:0] BASE [0:SEMITONES-1] = '{
        16'd22473, 16'd23810, 16'd25226, 16'd26726, 16'd28315, 16'd29998,
        16'd31782, 16'd33672, 16'd35674, 16'd37796, 16'd40043, 16'd42424
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        CALC  = 2'd2,
        GLIDE = 2'd3
    } note_state_t;

    function automatic logic [31:0] note_word(input logic [3:0] semi, input logic [3:0] oct);
        logic [31:0] base;
        base = (semi < 4'(SEMITONES)) ? 32'(BASE[semi]) : 32'd0;
        return (base >> (4'(MAX_OCT) - oct)) & ACC_MASK;
    endfunction

endpackage

// File: rtl/glide_ramp.sv
// rtl/glide_ramp.sv - glide prescaler, exponential step and the tuning-word register
module glide_ramp #(
    parameter int GLIDE_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        retarget,
    input  logic        run,
    input  logic [31:0] target,
    input  logic [3:0]  shift,
    output logic [31:0] value,
    output logic        done
);

    localparam int CW = $clog2(GLIDE_DIV);

    logic [CW-1:0]      cnt;
    logic [31:0]        tgt;
    logic               tick;
    logic signed [32:0] diff;
    logic [31:0]        mag;
    logic [31:0]        shifted;
    logic [31:0]        step;

    assign tick    = (cnt == CW'(GLIDE_DIV - 1));
    assign diff    = $signed({1'b0, tgt}) - $signed({1'b0, value});
    assign mag     = diff[32] ? 32'(-diff) : diff[31:0];
    assign shifted = mag >> shift;
    // Forcing a minimum step of one guarantees the ramp always lands on target.
    assign step    = (shifted == 32'd0) ? 32'd1 : shifted;
    assign done    = run && tick && (diff == 33'sd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            tgt   <= '0;
            value <= '0;
        end else begin
            if (retarget) begin
                cnt <= '0;
                tgt <= target;
            end else begin
                cnt <= tick ? '0 : cnt + CW'(1);
            end

            if (load) begin
                value <= target;
            end else if (run && tick && (diff != 33'sd0)) begin
                value <= diff[32] ? value - step : value + step;
            end
        end
    end

endmodule

// File: rtl/note_tuning_gen.sv
// rtl/note_tuning_gen.sv - MIDI note to phase tuning word with optional exponential glide
module note_tuning_gen
    import dds_pkg::*;
#(
    parameter int GLIDE_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  note,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [3:0]  glide_shift,
    output logic [31:0] tuning_word,
    output logic        gliding
);

    note_state_t state;
    logic [6:0]  rem;
    logic [3:0]  oct;
    logic [3:0]  shift_r;
    logic        accept;
    logic        in_calc;
    logic        ramp_run;
    logic        ramp_done;
    logic [31:0] calc_word;

    assign note_ready = (state == IDLE) || (state == GLIDE);
    assign gliding    = (state == GLIDE);
    assign accept     = note_valid && note_ready;
    assign in_calc    = (state == CALC);
    // A tick landing on the same edge as a new note is dropped; the new note wins.
    assign ramp_run   = gliding && !accept;
    assign calc_word  = note_word(rem[3:0], oct);

    glide_ramp #(
        .GLIDE_DIV (GLIDE_DIV)
    ) u_ramp (
        .clk      (clk),
        .rst      (rst),
        .load     (in_calc && (shift_r == 4'd0)),
        .retarget (in_calc),
        .run      (ramp_run),
        .target   (calc_word),
        .shift    (shift_r),
        .value    (tuning_word),
        .done     (ramp_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rem     <= '0;
            oct     <= '0;
            shift_r <= '0;
        end else begin
            case (state)
                IDLE, GLIDE: begin
                    if (accept) begin
                        rem     <= note;
                        oct     <= '0;
                        shift_r <= glide_shift;
                        state   <= DIV;
                    end else if (ramp_done) begin
                        state <= IDLE;
                    end
                end
                DIV: begin
                    if (rem >= 7'(SEMITONES)) begin
                        rem <= rem - 7'(SEMITONES);
                        oct <= oct + 4'd1;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    state <= (shift_r == 4'd0) ? IDLE : GLIDE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/note_tuning_gen.md
# note_tuning_gen

Converts a 7-bit MIDI note number into the 32-bit tuning word consumed by the phase counter, with optional exponential glide (portamento) between successive notes. It sits directly upstream of the phase accumulator, so a note change becomes a smooth or instantaneous pitch change of the saw output. Frequency scaling assumes a 100 MHz clock and a 28-bit phase accumulator (f_out = tuning_word · 100e6 / 2^28).

## Interface
- GLIDE_DIV, default 1024: clocks per glide tick (prescaler period), ≥ 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- note  in  7  MIDI note number, 0..127.
- note_valid  in  1  note present; transfer on note_valid && note_ready at a rising edge.
- note_ready  out  1  block can accept a note.
- glide_shift  in  4  glide coefficient, sampled with the note; 0 means jump immediately.
- tuning_word  out  32  tuning word to the phase counter, registered.
- gliding  out  1  high while tuning_word is ramping toward the target.

## Operation
- FSM states: IDLE, DIV, CALC, GLIDE. Reset state is IDLE.
- note_ready = 1 in IDLE and GLIDE, 0 in DIV and CALC. A new note in GLIDE retargets; the current tuning_word is held and the ramp restarts from it.
- On accept: rem ← note, oct ← 0, shift_r ← glide_shift, go to DIV.
- DIV: each cycle, if rem ≥ 12 then rem −= 12 and oct += 1; otherwise go to CALC. The loop takes oct+1 cycles; oct max is 10.
- CALC: target ← BASE[rem] >> (10 − oct), zero-extended to 32 bits. The glide prescaler counter is cleared.
  - If shift_r == 0: tuning_word ← target, next state IDLE.
  - Otherwise, next state GLIDE.
- GLIDE: on each prescaler tick, d = |target − tuning_word| and step = max(d >> shift_r, 1). tuning_word moves toward target by step and cannot overshoot. When tuning_word == target, go to IDLE.
- gliding = (state == GLIDE).
- Arithmetic: the difference is computed at 33 bits signed, and the step is unsigned 32-bit.
- BASE holds the tuning words for notes 120..131 (octave 10), rounded to nearest: 22473, 23810, 25226, 26726, 28315, 29998, 31782, 33672, 35674, 37796, 40043, 42424.
- Results: note 69 → 37796 >> 5 = 1181; note 60 → 702; note 0 → 21; note 127 → 33672.
- Prescaler: free-running counter 0..GLIDE_DIV−1 that ticks on wrap and is cleared in CALC.

## Timing
- Reset (rst low, asynchronous):
  - tuning_word = 0, gliding = 0, state = IDLE, note_ready = 1.
  - oct, rem, target and the prescaler are all cleared.
- Accept at edge E0. With shift_r == 0, tuning_word holds the new value after edge E(oct+2).
  - Note 69: 7 cycles.
  - Note 0: 2 cycles.
  - Note 127: 12 cycles.
- note_ready drops the cycle after acceptance and returns the cycle after CALC (IDLE or GLIDE).
- note_valid while note_ready = 0 is not accepted; the source must hold the note.
- Same target re-sent: with shift 0, the output is unchanged. With shift ≠ 0, the block enters GLIDE and exits on the first tick with no change to tuning_word.
- Reset mid-DIV or mid-GLIDE aborts immediately to the reset values above.
- In GLIDE, a tick that coincides with an accepted note is ignored. The new note path takes priority.

## Structure
- Package dds_pkg:
  - SEMITONES = 12, MAX_OCT = 10, ACC_BITS = 28.
  - The BASE[0:11] table.
  - State encoding typedef.
- Sub-module glide_ramp holds the prescaler, the step computation and the tuning_word register. Its interface is load / retarget / target / shift → value, done.
- The top level holds the FSM, the divide-by-12 loop and the table lookup.

## Test plan
- Reset: assert rst low mid-stream → tuning_word = 0, gliding = 0, note_ready = 1 asynchronously.
- Jump: note 69, shift 0 → tuning_word = 1181 exactly 7 cycles after accept. Then note 0 → 21 after 2 cycles; note 127 → 33672 after 12 cycles.
- Sweep: all notes 0..127 with shift 0 → each result matches BASE[n mod 12] >> (10 − n/12).
- Glide (GLIDE_DIV = 4): note 60 then note 69 with shift 1 → per-tick values 941, 1061, 1121, 1151, 1166, 1173, 1177, 1179, 1180, 1181. gliding then falls.
- Retarget: during that glide, after value 1121, send note 60 → ramp turns down from 1121 toward 702 with no jump. note_ready is low for exactly the DIV+CALC cycles.
- Backpressure: hold note_valid high during DIV with a changing note → only the note present at the note_ready edge is used.
